// File: rtl/myproject_mac_pipe.sv
// myproject_mac_pipe: pipelined signed multiply-accumulate with grouped accumulation, rounding and saturation
module myproject_mac_pipe #(
   parameter int DIN0_WIDTH = 16,
   parameter int DIN1_WIDTH = 12,
   parameter int ACC_WIDTH  = 32,
   parameter int DOUT_WIDTH = 16,
   parameter int NUM_STAGE  = 2,
   parameter int FRAC_SHIFT = 10
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         ce,
   input  logic signed [DIN0_WIDTH-1:0] din0,
   input  logic signed [DIN1_WIDTH-1:0] din1,
   input  logic                         in_valid,
   input  logic                         acc_clr,
   input  logic                         acc_last,
   output logic signed [DOUT_WIDTH-1:0] dout,
   output logic                         dout_valid,
   output logic                         ovf
);
   localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
   localparam int AW = ACC_WIDTH;
   localparam logic [AW:0] HALF = (FRAC_SHIFT == 0) ? '0 : {{AW{1'b0}}, 1'b1} << ((FRAC_SHIFT == 0) ? 0 : FRAC_SHIFT - 1);
   logic signed [DIN0_WIDTH-1:0] a_q, a_d;
   logic signed [DIN1_WIDTH-1:0] b_q, b_d;
   logic [2:0]                   it_q, it_d;
   logic signed [PW-1:0]         p_q [NUM_STAGE];
   logic signed [PW-1:0]         p_d [NUM_STAGE];
   logic [2:0]                   t_q [NUM_STAGE];
   logic [2:0]                   t_d [NUM_STAGE];
   logic signed [AW-1:0]         acc_q, acc_d;
   logic                         stk_q, stk_d;
   logic                         lst_q, lst_d;
   logic signed [DOUT_WIDTH-1:0] dout_q, dout_d;
   logic                         dv_q, dv_d;
   logic                         ovf_q, ovf_d;
   logic [2:0]                   tl;
   logic signed [AW:0]           pe, sum, rnd, r;
   logic                         sat, fits;
   logic [AW-DOUT_WIDTH+1:0]     hi;
   // operand capture and multiplier pipeline; tags {valid,clr,last} travel with the product
   always_comb begin
      a_d = din0;
      b_d = din1;
      it_d = {in_valid, acc_clr, acc_last};
      p_d[0] = PW'(a_q) * PW'(b_q);
      t_d[0] = it_q;
      for (int i = 1; i < NUM_STAGE; i++) begin
         p_d[i] = p_q[i-1];
         t_d[i] = t_q[i-1];
      end
   end
   // accumulator: clear loads the product, otherwise saturating add; one guard bit detects overflow
   always_comb begin
      tl = t_q[NUM_STAGE-1];
      pe = (AW+1)'(p_q[NUM_STAGE-1]);
      sum = {acc_q[AW-1], acc_q} + pe;
      sat = sum[AW] != sum[AW-1];
      acc_d = !tl[2] ? acc_q : tl[1] ? pe[AW-1:0] : sat ? {sum[AW], {(AW-1){~sum[AW]}}} : sum[AW-1:0];
      stk_d = !tl[2] ? stk_q : tl[1] ? 1'b0 : stk_q | sat;
      lst_d = tl[2] & tl[0];
   end
   // output: round half up with a guard bit, then saturate to the output width
   always_comb begin
      rnd = {acc_q[AW-1], acc_q} + HALF;
      r = rnd >>> FRAC_SHIFT;
      hi = r[AW:DOUT_WIDTH-1];
      fits = (&hi) | ~(|hi);
      dout_d = !lst_q ? dout_q : fits ? r[DOUT_WIDTH-1:0] : {r[AW], {(DOUT_WIDTH-1){~r[AW]}}};
      ovf_d = lst_q ? stk_q | ~fits : ovf_q;
      dv_d = lst_q;
   end
   // state registers: reset wins over ce, ce low freezes everything
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q <= '0;
         b_q <= '0;
         it_q <= '0;
         for (int i = 0; i < NUM_STAGE; i++) begin
            p_q[i] <= '0;
            t_q[i] <= '0;
         end
         acc_q <= '0;
         stk_q <= 1'b0;
         lst_q <= 1'b0;
         dout_q <= '0;
         dv_q <= 1'b0;
         ovf_q <= 1'b0;
      end else if (ce) begin
         a_q <= a_d;
         b_q <= b_d;
         it_q <= it_d;
         for (int i = 0; i < NUM_STAGE; i++) begin
            p_q[i] <= p_d[i];
            t_q[i] <= t_d[i];
         end
         acc_q <= acc_d;
         stk_q <= stk_d;
         lst_q <= lst_d;
         dout_q <= dout_d;
         dv_q <= dv_d;
         ovf_q <= ovf_d;
      end
   end
   assign dout = dout_q;
   assign dout_valid = dv_q;
   assign ovf = ovf_q;
endmodule

// File: doc/myproject_mac_pipe.md
# myproject_mac_pipe

Parametrised pipelined signed multiply-accumulate unit: the successor to the fixed two-operand `mul_*` product registers. It adds:
- a configurable multiplier pipeline depth
- valid tracking
- grouped accumulation with clear/last markers
- round-half-up fractional scaling
- saturation with a sticky overflow flag

It sits in the dense-layer datapath, where one instance computes a dot product per neuron from a stream of weight/activation pairs.

## Interface
- `DIN0_WIDTH`, 16, signed width of operand 0.
- `DIN1_WIDTH`, 12, signed width of operand 1.
- `ACC_WIDTH`, 32, signed accumulator width; must be ≥ `DIN0_WIDTH+DIN1_WIDTH`.
- `DOUT_WIDTH`, 16, signed output width.
- `NUM_STAGE`, 2, multiplier pipeline registers; must be ≥ 1.
- `FRAC_SHIFT`, 10, output right-shift; must be in 0..`ACC_WIDTH`-1.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `ce`  in  1  clock enable; when low, every register holds.
- `din0`  in  `DIN0_WIDTH`  signed operand 0.
- `din1`  in  `DIN1_WIDTH`  signed operand 1.
- `in_valid`  in  1  operands and markers valid this cycle.
- `acc_clr`  in  1  first sample of a group; qualified by `in_valid`.
- `acc_last`  in  1  final sample of a group; qualified by `in_valid`.
- `dout`  out  `DOUT_WIDTH`  rounded, saturated group result.
- `dout_valid`  out  1  `dout`/`ovf` valid.
- `ovf`  out  1  saturation occurred in the reported group.

## Operation
- **Sample acceptance:** a sample is accepted on a rising edge with `reset`=0, `ce`=1 and `in_valid`=1.
- **Multiplier pipeline:** product P = `din0`×`din1` at full width `DIN0_WIDTH+DIN1_WIDTH`, signed. P passes through `NUM_STAGE` registers, with `valid`/`clr`/`last` tags delayed alongside it.
- **Accumulator stage:** acts only when the tag valid=1. P is sign-extended to `ACC_WIDTH`.
  - `clr`=1: acc ← sext(P), and the sticky overflow is cleared before this sample is evaluated.
  - `clr`=0: acc ← sat(acc + sext(P)). On saturation, acc clamps to ±(2^(`ACC_WIDTH`-1)) bound (max 2^(ACC_WIDTH-1)-1, min -2^(ACC_WIDTH-1)) and the sticky overflow is set.
  - Bubbles (valid=0) leave acc and the sticky overflow unchanged.
- **Missing clear:** `acc_last` without any preceding `acc_clr` continues from the current acc. No error is raised.
- **Single-product mode:** `acc_clr`=`acc_last`=1 on the same sample gives a pipelined multiply with scaling.
- **Output stage:** registered; fires one stage after the accumulator when that sample carried `last`.
  - Rounding: R = (acc + 2^(`FRAC_SHIFT`-1)) >>> `FRAC_SHIFT`, computed with one guard bit so the rounding add cannot wrap. With `FRAC_SHIFT`=0 there is no add.
  - R is saturated to `DOUT_WIDTH` signed. Output saturation also sets `ovf` for that result.
  - `ovf` = sticky overflow of the group OR output saturation.
  - `dout_valid`=1 for exactly one enabled cycle per `last` sample. Otherwise `dout_valid`=0, and `dout`/`ovf` hold their last reported values.
- **Reset:** clears all pipeline valid tags, acc, sticky overflow, `dout`=0, `dout_valid`=0 and `ovf`=0. A partial group in flight is discarded and produces no output.

## Timing
- Latency: a `last` sample accepted at edge t gives `dout_valid`=1 after edge t+`NUM_STAGE`+2, counting enabled edges only.
- Throughput: one sample per enabled cycle, with no stalls. Back-to-back groups are allowed: `clr` immediately after `last` is valid.
- **`ce`=0:** all registers, including `dout_valid`, hold. Downstream qualifies `dout_valid` with `ce`.
- **`reset` and `ce`:** `reset` has priority over `ce`; reset acts even when `ce`=0.
- **Flush:** all state is flushed in one cycle of `reset`. The first sample may be accepted on the edge after `reset` deasserts.

## Test plan
Defaults throughout (16/12/32/16, `NUM_STAGE`=2, `FRAC_SHIFT`=10).
- **Single multiply:** `din0`=1024, `din1`=1024, `clr`=`last`=1 → exactly 4 cycles later `dout`=1024, `ovf`=0, `dout_valid` high for one cycle.
- **Rounding:**
  - 2×256 (512) → 1
  - −2×256 (−512) → 0
  - 3×171 (513) → 1
  - −3×171 (−513) → −1
- **Group with bubble:** samples (1024,1024,clr), (−1024,512), bubble, (2048,256), (512,512,last) → `dout`=1280, a single `dout_valid`, `ovf`=0.
- **Output saturation:** −32768×−2048 single → `dout`=32767, `ovf`=1.
- **Accumulator saturation:** 40 samples of −32768×−2048 in one group → acc clamps at 2147483647, `dout`=32767, `ovf`=1. A following single group 1024×1024 → `dout`=1024, `ovf`=0.
- **`ce` and reset:** drop `ce` for 3 cycles mid-group → result value unchanged and latency extended by 3. Assert `reset` mid-group → no `dout_valid`, all outputs 0, and the next group is correct.
